// File: rtl/spi_master_mmio_pkg.sv
// Shared definitions for the memory-mapped SPI master.
// Contents: CPU data-port command encodings and widths, register offsets
// within the 16-byte window, STATUS bit positions and the shift-engine
// FSM state encoding.
package spi_master_mmio_pkg;

   localparam int W_MEM_CMD = 2;
   localparam int W_CPU     = 32;

   localparam logic [W_MEM_CMD-1:0] MEM_NOP   = 2'd0;
   localparam logic [W_MEM_CMD-1:0] MEM_READ  = 2'd1;
   localparam logic [W_MEM_CMD-1:0] MEM_WRITE = 2'd2;

   localparam logic [1:0] SPI_OFF_TX   = 2'd0;
   localparam logic [1:0] SPI_OFF_RX   = 2'd1;
   localparam logic [1:0] SPI_OFF_STAT = 2'd2;
   localparam logic [1:0] SPI_OFF_CTRL = 2'd3;

   localparam int STAT_BUSY = 0;
   localparam int STAT_RXV  = 1;
   localparam int STAT_OVR  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEAD  = 2'd1,
      ST_TRAIL = 2'd2,
      ST_DONE  = 2'd3
   } spi_state_t;

endpackage

// File: rtl/spi_master_mmio_if.sv
// CPU data-port bundle between the core (master) and the SPI register
// window (slave).
//   mem_cmd : MEM_NOP / MEM_READ / MEM_WRITE
//   addr    : byte address
//   wdata   : store data
//   rdata   : combinational load data, 0 when not hit
//   hit     : address falls inside the slave's window
interface spi_master_mmio_if;
   import spi_master_mmio_pkg::*;

   logic [W_MEM_CMD-1:0] mem_cmd;
   logic [W_CPU-1:0]     addr;
   logic [W_CPU-1:0]     wdata;
   logic [W_CPU-1:0]     rdata;
   logic                 hit;

   modport master (output mem_cmd, addr, wdata, input rdata, hit);
   modport slave  (input mem_cmd, addr, wdata, output rdata, hit);
endinterface

// File: rtl/spi_master_mmio_shift_engine.sv
// SPI mode-0 byte shifter: FSM, half-period counter, shift registers and pins.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start           : begin a transfer of txbyte (ignored unless idle)
//   txbyte          : byte to send, MSB first
//   div             : half-period minus one, latched at start
//   busy            : high from the start edge until the DONE cycle ends
//   done            : one-cycle strobe while rxbyte is complete
//   rxbyte          : received byte
//   sclk, mosi, cs_n, miso : SPI pins
module spi_shift_engine
   import spi_master_mmio_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] txbyte,
   input  logic [7:0] div,
   output logic       busy,
   output logic       done,
   output logic [7:0] rxbyte,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       cs_n
);

   spi_state_t r_state, w_state_nxt;
   logic [7:0] r_cnt,    w_cnt_nxt;
   logic [7:0] r_hm1,    w_hm1_nxt;
   logic [7:0] r_shreg,  w_shreg_nxt;
   logic [7:0] r_rxsh,   w_rxsh_nxt;
   logic [2:0] r_bitcnt, w_bitcnt_nxt;
   logic       r_sclk,   w_sclk_nxt;
   logic       r_mosi,   w_mosi_nxt;
   logic       r_cs_n,   w_cs_n_nxt;
   logic       r_busy,   w_busy_nxt;
   logic       w_phase_end;

   // Half-period is H = div+1 cycles, so a phase ends when cnt reaches div;
   // with div=8'hFF this is 255 and the 8-bit counter never needs value 256.
   assign w_phase_end = (r_cnt == r_hm1);

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_hm1_nxt    = r_hm1;
      w_shreg_nxt  = r_shreg;
      w_rxsh_nxt   = r_rxsh;
      w_bitcnt_nxt = r_bitcnt;
      w_sclk_nxt   = r_sclk;
      w_mosi_nxt   = r_mosi;
      w_cs_n_nxt   = r_cs_n;
      w_busy_nxt   = r_busy;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_shreg_nxt  = txbyte;
               w_hm1_nxt    = div;
               w_bitcnt_nxt = 3'd0;
               w_cs_n_nxt   = 1'b0;
               w_mosi_nxt   = txbyte[7];
               w_busy_nxt   = 1'b1;
               w_cnt_nxt    = 8'd0;
               w_state_nxt  = ST_LEAD;
            end
         end
         ST_LEAD: begin
            if (w_phase_end) begin
               w_sclk_nxt  = 1'b1;
               w_rxsh_nxt  = {r_rxsh[6:0], miso};
               w_cnt_nxt   = 8'd0;
               w_state_nxt = ST_TRAIL;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         ST_TRAIL: begin
            if (w_phase_end) begin
               w_sclk_nxt = 1'b0;
               w_cnt_nxt  = 8'd0;
               if (r_bitcnt == 3'd7) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  // Next bit goes out on the falling edge so it is stable
                  // for a full low phase before the slave samples it.
                  w_shreg_nxt  = {r_shreg[6:0], 1'b0};
                  w_mosi_nxt   = r_shreg[6];
                  w_bitcnt_nxt = r_bitcnt + 3'd1;
                  w_state_nxt  = ST_LEAD;
               end
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         ST_DONE: begin
            w_cs_n_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_mosi_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 8'd0;
         r_hm1    <= 8'd0;
         r_shreg  <= 8'd0;
         r_rxsh   <= 8'd0;
         r_bitcnt <= 3'd0;
         r_sclk   <= 1'b0;
         r_mosi   <= 1'b0;
         r_cs_n   <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_hm1    <= w_hm1_nxt;
         r_shreg  <= w_shreg_nxt;
         r_rxsh   <= w_rxsh_nxt;
         r_bitcnt <= w_bitcnt_nxt;
         r_sclk   <= w_sclk_nxt;
         r_mosi   <= w_mosi_nxt;
         r_cs_n   <= w_cs_n_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign busy   = r_busy;
   assign done   = (r_state == ST_DONE);
   assign rxbyte = r_rxsh;
   assign sclk   = r_sclk;
   assign mosi   = r_mosi;
   assign cs_n   = r_cs_n;

endmodule

// File: rtl/spi_master_mmio.sv
// Memory-mapped SPI master on the CPU data port.
// Decodes a 16-byte window at BASE_ADDR, holds the TX/RX/STATUS/CTRL
// registers and drives one 8-bit mode-0 transfer per TXDATA write.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   bus (slave modport)   : mem_cmd/addr/wdata in, rdata/hit out (combinational)
//   sclk, mosi, cs_n      : SPI outputs (idle 0, 0, 1)
//   miso                  : SPI input
module spi_master_mmio
   import spi_master_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter logic [7:0]  DIV_RST   = 8'd3
)(
   input  logic              clk,
   input  logic              rst,
   spi_master_mmio_if.slave  bus,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs_n
);

   logic       w_hit, w_wr, w_rd, w_start, w_ovr_set, w_ovr_clr;
   logic       w_busy, w_done;
   logic [1:0] w_off;
   logic [7:0] w_rxbyte;
   logic       w_unused;
   logic [7:0] r_div;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_ovr;

   assign w_hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign w_off     = bus.addr[3:2];
   assign w_wr      = w_hit && (bus.mem_cmd == MEM_WRITE);
   assign w_rd      = w_hit && (bus.mem_cmd == MEM_READ);
   // busy stays high through the DONE cycle, so a TXDATA write landing on
   // the completing edge is treated as an overrun rather than a new start.
   assign w_start   = w_wr && (w_off == SPI_OFF_TX) && !w_busy;
   assign w_ovr_set = w_wr && (w_off == SPI_OFF_TX) && w_busy;
   assign w_ovr_clr = w_wr && (w_off == SPI_OFF_STAT) && bus.wdata[STAT_OVR];
   assign w_unused  = &{1'b0, bus.wdata[31:8], bus.addr[1:0]};

   spi_shift_engine u_engine (
      .clk    (clk),
      .rst    (rst),
      .start  (w_start),
      .txbyte (bus.wdata[7:0]),
      .div    (r_div),
      .busy   (w_busy),
      .done   (w_done),
      .rxbyte (w_rxbyte),
      .sclk   (sclk),
      .mosi   (mosi),
      .miso   (miso),
      .cs_n   (cs_n)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div      <= DIV_RST;
         r_rx_data  <= 8'd0;
         r_rx_valid <= 1'b0;
         r_ovr      <= 1'b0;
      end else begin
         if (w_wr && (w_off == SPI_OFF_CTRL) && !w_busy) r_div <= bus.wdata[7:0];
         if (w_done) r_rx_data <= w_rxbyte;
         // Set beats clear when both land on the same edge.
         if (w_done) r_rx_valid <= 1'b1;
         else if (w_rd && (w_off == SPI_OFF_RX)) r_rx_valid <= 1'b0;
         if (w_ovr_set) r_ovr <= 1'b1;
         else if (w_ovr_clr) r_ovr <= 1'b0;
      end
   end

   always_comb begin
      bus.rdata = '0;
      if (w_hit) begin
         case (w_off)
            SPI_OFF_RX:   bus.rdata = {24'd0, r_rx_data};
            SPI_OFF_STAT: bus.rdata = {29'd0, r_ovr, r_rx_valid, w_busy};
            SPI_OFF_CTRL: bus.rdata = {24'd0, r_div};
            default:      bus.rdata = '0;
         endcase
      end
   end

   assign bus.hit = w_hit;

endmodule

// File: tb/tb_spi_master_mmio.sv
module tb_spi_master_mmio;
   import spi_master_mmio_pkg::*;

   localparam logic [31:0] A_TX = 32'h0000_1000;
   localparam logic [31:0] A_RX = 32'h0000_1004;
   localparam logic [31:0] A_ST = 32'h0000_1008;
   localparam logic [31:0] A_CT = 32'h0000_100C;

   logic clk = 1'b0;
   logic rst;
   logic sclk, mosi, cs_n, miso;
   logic loopback;
   logic miso_val;

   int n_vec = 0;
   int n_err = 0;

   spi_master_mmio_if bus ();

   assign miso = loopback ? mosi : miso_val;

   spi_master_mmio #(.BASE_ADDR(32'h0000_1000), .DIV_RST(8'd3)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .sclk (sclk),
      .mosi (mosi),
      .miso (miso),
      .cs_n (cs_n)
   );

   always #5 clk = ~clk;

   // Transfer monitor, sampled on the falling clock edge.
   int mon_gen = 0;
   int mon_seen = 0;
   int cs_low, busy_cyc, rises, hi_run, lo_run, hi_min, hi_max, lo_min, lo_max;
   logic [7:0] tx_cap;
   logic sclk_q;

   always @(negedge clk) begin
      if (mon_gen != mon_seen) begin
         mon_seen = mon_gen;
         cs_low = 0; busy_cyc = 0; rises = 0; hi_run = 0; lo_run = 0;
         hi_min = 100000; hi_max = 0; lo_min = 100000; lo_max = 0;
         tx_cap = 8'h00; sclk_q = 1'b0;
      end else begin
         if (!cs_n) cs_low++;
         if (bus.hit && bus.mem_cmd == MEM_READ && bus.addr[3:2] == 2'd2 && bus.rdata[0])
            busy_cyc++;
         if (sclk) begin
            if (!sclk_q) begin
               rises++;
               tx_cap = {tx_cap[6:0], mosi};
               if (lo_run > 0) begin
                  if (lo_run < lo_min) lo_min = lo_run;
                  if (lo_run > lo_max) lo_max = lo_run;
               end
            end
            lo_run = 0;
            hi_run++;
         end else begin
            if (sclk_q && hi_run > 0) begin
               if (hi_run < hi_min) hi_min = hi_run;
               if (hi_run > hi_max) hi_max = hi_run;
            end
            hi_run = 0;
            if (!cs_n) lo_run++;
         end
         sclk_q = sclk;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk); #2;
      bus.mem_cmd = MEM_WRITE; bus.addr = a; bus.wdata = d;
      @(posedge clk); #1;
      bus.mem_cmd = MEM_NOP;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
      @(negedge clk); #2;
      bus.mem_cmd = MEM_READ; bus.addr = a;
      #1 d = bus.rdata; h = bus.hit;
      @(posedge clk); #1;
      bus.mem_cmd = MEM_NOP;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic h;
      bus_read(a, d, h);
      chk(tag, d, exp);
   endtask

   // Holds a STATUS read so the monitor can count busy cycles; bounded.
   task automatic wait_idle(input string tag, input int budget);
      bit idle;
      idle = 1'b0;
      bus.mem_cmd = MEM_READ; bus.addr = A_ST;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (!bus.rdata[0]) begin idle = 1'b1; break; end
      end
      bus.mem_cmd = MEM_NOP;
      chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
   endtask

   initial begin
      logic [31:0] d;
      logic h;
      rst = 1'b0; loopback = 1'b1; miso_val = 1'b0;
      bus.mem_cmd = MEM_NOP; bus.addr = 32'd0; bus.wdata = 32'd0;

      // Reset state
      #12;
      chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
      chk("rst_sclk", {31'd0, sclk}, 32'd0);
      chk("rst_mosi", {31'd0, mosi}, 32'd0);
      rd_chk("rst_ctrl", A_CT, 32'd3);
      rd_chk("rst_stat", A_ST, 32'd0);
      rd_chk("rst_rx",   A_RX, 32'd0);
      @(negedge clk); #2 rst = 1'b1;

      // Loopback, div=0, 0xA5
      bus_write(A_CT, 32'd0);
      mon_gen++;
      bus_write(A_TX, 32'hA5);
      wait_idle("lb", 200);
      chk("lb_busy_cycles", busy_cyc, 32'd17);
      chk("lb_cs_low",      cs_low, 32'd17);
      chk("lb_rises",       rises, 32'd8);
      chk("lb_hi_min",      hi_min, 32'd1);
      chk("lb_hi_max",      hi_max, 32'd1);
      chk("lb_tx",          {24'd0, tx_cap}, 32'hA5);
      rd_chk("lb_stat1", A_ST, 32'h2);
      rd_chk("lb_rx",    A_RX, 32'hA5);
      rd_chk("lb_stat2", A_ST, 32'h0);
      rd_chk("lb_rx_hold", A_RX, 32'hA5);

      // Timing, div=3, miso=1, 0x3C
      bus_write(A_CT, 32'd3);
      loopback = 1'b0; miso_val = 1'b1;
      mon_gen++;
      bus_write(A_TX, 32'h3C);
      wait_idle("tm", 400);
      chk("tm_busy_cycles", busy_cyc, 32'd65);
      chk("tm_cs_low",      cs_low, 32'd65);
      chk("tm_rises",       rises, 32'd8);
      chk("tm_tx",          {24'd0, tx_cap}, 32'h3C);
      chk("tm_hi_min",      hi_min, 32'd4);
      chk("tm_hi_max",      hi_max, 32'd4);
      chk("tm_lo_min",      lo_min, 32'd4);
      chk("tm_lo_max",      lo_max, 32'd4);
      rd_chk("tm_rx", A_RX, 32'hFF);

      // Overrun
      loopback = 1'b1;
      mon_gen++;
      bus_write(A_TX, 32'h11);
      bus_write(A_TX, 32'h22);
      wait_idle("ov", 400);
      chk("ov_tx",    {24'd0, tx_cap}, 32'h11);
      chk("ov_rises", rises, 32'd8);
      rd_chk("ov_stat_set", A_ST, 32'h6);
      bus_write(A_ST, 32'h4);
      rd_chk("ov_stat_clr", A_ST, 32'h2);
      rd_chk("ov_rx", A_RX, 32'h11);

      // CTRL write while busy is ignored
      mon_gen++;
      bus_write(A_TX, 32'h5A);
      bus_write(A_CT, 32'd7);
      rd_chk("cb_ctrl_busy", A_CT, 32'd3);
      wait_idle("cb", 400);
      chk("cb_cs_low", cs_low, 32'd65);
      chk("cb_hi_max", hi_max, 32'd4);
      chk("cb_lo_max", lo_max, 32'd4);
      chk("cb_tx",     {24'd0, tx_cap}, 32'h5A);
      rd_chk("cb_ctrl_after", A_CT, 32'd3);
      rd_chk("cb_rx", A_RX, 32'h5A);

      // TXDATA write on the completing edge is an overrun
      bus_write(A_CT, 32'd0);
      mon_gen++;
      bus_write(A_TX, 32'h81);
      repeat (16) @(posedge clk);
      bus_write(A_TX, 32'h42);
      repeat (6) @(posedge clk);
      #1;
      chk("dn_rises",  rises, 32'd8);
      chk("dn_cs_low", cs_low, 32'd17);
      chk("dn_tx",     {24'd0, tx_cap}, 32'h81);
      rd_chk("dn_stat", A_ST, 32'h6);
      rd_chk("dn_rx",   A_RX, 32'h81);
      bus_write(A_ST, 32'h4);
      rd_chk("dn_stat_clr", A_ST, 32'h0);

      // Address decode and NOP
      bus_write(A_CT, 32'd6);
      mon_gen++;
      @(negedge clk); #2;
      bus.mem_cmd = MEM_WRITE; bus.addr = 32'h0000_1010; bus.wdata = 32'hAA;
      #1;
      chk("dec_wr_hit",   {31'd0, bus.hit}, 32'd0);
      chk("dec_wr_rdata", bus.rdata, 32'd0);
      @(posedge clk); #1 bus.mem_cmd = MEM_NOP;
      bus_write(32'h0000_101C, 32'd9);
      @(negedge clk); #2;
      bus.mem_cmd = MEM_NOP; bus.addr = A_TX; bus.wdata = 32'hFF;
      repeat (4) @(posedge clk);
      #1;
      chk("dec_no_xfer", cs_low, 32'd0);
      bus_read(32'h0000_0FFC, d, h);
      chk("dec_rd_hit",   {31'd0, h}, 32'd0);
      chk("dec_rd_rdata", d, 32'd0);
      rd_chk("dec_ctrl", A_CT, 32'd6);
      rd_chk("dec_stat", A_ST, 32'd0);

      // Reset mid-transfer
      bus_write(A_TX, 32'h77);
      repeat (10) @(posedge clk);
      #1;
      chk("mr_active", {31'd0, cs_n}, 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("mr_cs_n", {31'd0, cs_n}, 32'd1);
      chk("mr_sclk", {31'd0, sclk}, 32'd0);
      chk("mr_mosi", {31'd0, mosi}, 32'd0);
      rd_chk("mr_stat", A_ST, 32'd0);
      rd_chk("mr_rx",   A_RX, 32'd0);
      rd_chk("mr_ctrl", A_CT, 32'd3);
      @(negedge clk); #2 rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("mr_idle_cs_n", {31'd0, cs_n}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
